// File: rtl/alu_writeback.sv
// -----------------------------------------------------------------------------
// alu_writeback
//
// Single-issue ALU that computes one result per accepted operation and writes
// it back to the eax register. A write is requested by driving WRITE_CODE on
// read_or_write for exactly one cycle. MOV/ADD/SUB/AND/OR/XOR take one cycle.
// SHL shifts one bit per cycle. MUL is an iterative 32-step shift-add.
//
// Optional feature macro:
//   ALU_MUL_EN : when defined, opcode 7 (MUL) is implemented. When it is
//                undefined there is no multiplier logic, and opcode 7 is
//                answered with a one-cycle err pulse and no write.
//
// Ports:
//   clock          in   sole clock, rising edge
//   reset          in   synchronous active-low reset
//   op_valid       in   operation request valid
//   op_ready       out  high only in IDLE (an operation can be accepted)
//   opcode[2:0]    in   0 MOV, 1 ADD, 2 SUB, 3 AND, 4 OR, 5 XOR, 6 SHL, 7 MUL
//   src_a[31:0]    in   first operand (normally current eax)
//   src_b[31:0]    in   second operand / immediate / shift count in [4:0]
//   write_data     out  last result for eax (holds between results)
//   read_or_write  out  WRITE_CODE during the writeback cycle, else 4'h0
//   done           out  one-cycle pulse with each result
//   err            out  one-cycle pulse for an unsupported opcode
//   zf, cf         out  zero and carry/borrow flags, updated only on writeback
// -----------------------------------------------------------------------------
module alu_writeback #(
  parameter logic [3:0] WRITE_CODE = 4'h3
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        op_valid,
  output logic        op_ready,
  input  logic [2:0]  opcode,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  output logic [31:0] write_data,
  output logic [3:0]  read_or_write,
  output logic        done,
  output logic        err,
  output logic        zf,
  output logic        cf
);

  localparam logic [2:0] OP_MOV = 3'd0;
  localparam logic [2:0] OP_ADD = 3'd1;
  localparam logic [2:0] OP_SUB = 3'd2;
  localparam logic [2:0] OP_AND = 3'd3;
  localparam logic [2:0] OP_OR  = 3'd4;
  localparam logic [2:0] OP_XOR = 3'd5;
  localparam logic [2:0] OP_SHL = 3'd6;
  localparam logic [2:0] OP_MUL = 3'd7;

  typedef enum logic [1:0] {IDLE, EXEC, WB} state_t;

  state_t      state;
  logic [31:0] acc;       // running shift value (SHL) or partial product (MUL)
  logic [5:0]  cnt;       // EXEC steps still to do, including the current one

`ifdef ALU_MUL_EN
  logic        is_mul;
  logic [31:0] mul_a;     // multiplicand, shifted left each step
  logic [31:0] mul_b;     // multiplier, shifted right each step
`endif

  // Single-cycle ALU result from the live inputs (used only on acceptance).
  logic [31:0] alu_res;
  logic        alu_cf;

  // NOTE: every signal written in always_comb gets a default first, so no
  // path through the case leaves it unassigned and no latch is inferred.
  always_comb begin
    alu_res = src_b;
    alu_cf  = 1'b0;
    unique case (opcode)
      OP_MOV: alu_res = src_b;
      OP_ADD: {alu_cf, alu_res} = {1'b0, src_a} + {1'b0, src_b};
      OP_SUB: begin
        alu_res = src_a - src_b;
        alu_cf  = (src_a < src_b);
      end
      OP_AND: alu_res = src_a & src_b;
      OP_OR:  alu_res = src_a | src_b;
      OP_XOR: alu_res = src_a ^ src_b;
      default: alu_res = src_a;   // SHL/MUL do not use this path
    endcase
  end

  // Value the accumulator takes after one EXEC step.
  logic [31:0] exec_next;

  always_comb begin
    exec_next = acc << 1;
`ifdef ALU_MUL_EN
    if (is_mul) exec_next = acc + (mul_b[0] ? mul_a : 32'h0);
`endif
  end

  // Writeback request for this edge: either a one-cycle op being accepted,
  // a zero-count SHL, or the last EXEC step of SHL/MUL.
  logic        wb_fire;
  logic [31:0] wb_val;
  logic        wb_cf;

  always_comb begin
    wb_fire = 1'b0;
    wb_val  = exec_next;
    wb_cf   = 1'b0;
    unique case (state)
      IDLE: begin
        if (op_valid) begin
          if (opcode == OP_SHL) begin
            if (src_b[4:0] == 5'd0) begin
              wb_fire = 1'b1;
              wb_val  = src_a;
            end
          end else if (opcode != OP_MUL) begin
            wb_fire = 1'b1;
            wb_val  = alu_res;
            wb_cf   = alu_cf;
          end
        end
      end
      EXEC: begin
        if (cnt == 6'd1) wb_fire = 1'b1;
      end
      default: ;
    endcase
  end

  assign op_ready = (state == IDLE);

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the values from before this edge.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state         <= IDLE;
      acc           <= 32'h0;
      cnt           <= 6'd0;
      write_data    <= 32'h0;
      read_or_write <= 4'h0;
      done          <= 1'b0;
      err           <= 1'b0;
      zf            <= 1'b0;
      cf            <= 1'b0;
`ifdef ALU_MUL_EN
      is_mul        <= 1'b0;
      mul_a         <= 32'h0;
      mul_b         <= 32'h0;
`endif
    end else begin
      // Pulses last a single cycle unless re-asserted below.
      read_or_write <= 4'h0;
      done          <= 1'b0;
      err           <= 1'b0;

      if (wb_fire) begin
        write_data    <= wb_val;
        read_or_write <= WRITE_CODE;
        done          <= 1'b1;
        zf            <= (wb_val == 32'h0);
        cf            <= wb_cf;
      end

      unique case (state)
        IDLE: begin
          if (op_valid) begin
            if (wb_fire) begin
              state <= WB;
            end else if (opcode == OP_SHL) begin
              acc   <= src_a;
              cnt   <= {1'b0, src_b[4:0]};
              state <= EXEC;
`ifdef ALU_MUL_EN
              is_mul <= 1'b0;
`endif
            end else begin
`ifdef ALU_MUL_EN
              acc    <= 32'h0;
              cnt    <= 6'd32;
              is_mul <= 1'b1;
              mul_a  <= src_a;
              mul_b  <= src_b;
              state  <= EXEC;
`else
              // No multiplier built: flag the op, leave result and flags.
              err   <= 1'b1;
              state <= WB;
`endif
            end
          end
        end
        EXEC: begin
          acc <= exec_next;
          cnt <= cnt - 6'd1;
`ifdef ALU_MUL_EN
          mul_a <= mul_a << 1;
          mul_b <= mul_b >> 1;
`endif
          if (wb_fire) state <= WB;
        end
        WB:      state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_writeback.sv
// -----------------------------------------------------------------------------
// tb_alu_writeback
//
// Directed self-checking bench for alu_writeback. Each task drives one
// scenario and compares outputs against hand-computed values. Inputs are
// driven and outputs sampled 1 time unit after the rising clock edge.
// -----------------------------------------------------------------------------
module tb_alu_writeback;

  localparam logic [3:0] WC = 4'h3;

  localparam logic [2:0] OP_MOV = 3'd0;
  localparam logic [2:0] OP_ADD = 3'd1;
  localparam logic [2:0] OP_SUB = 3'd2;
  localparam logic [2:0] OP_AND = 3'd3;
  localparam logic [2:0] OP_OR  = 3'd4;
  localparam logic [2:0] OP_XOR = 3'd5;
  localparam logic [2:0] OP_SHL = 3'd6;
  localparam logic [2:0] OP_MUL = 3'd7;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        op_valid = 1'b0;
  logic        op_ready;
  logic [2:0]  opcode = 3'd0;
  logic [31:0] src_a = 32'h0;
  logic [31:0] src_b = 32'h0;
  logic [31:0] write_data;
  logic [3:0]  read_or_write;
  logic        done, err, zf, cf;

  int errors = 0;
  int checks = 0;

  alu_writeback #(.WRITE_CODE(WC)) dut (
    .clock         (clock),
    .reset         (reset),
    .op_valid      (op_valid),
    .op_ready      (op_ready),
    .opcode        (opcode),
    .src_a         (src_a),
    .src_b         (src_b),
    .write_data    (write_data),
    .read_or_write (read_or_write),
    .done          (done),
    .err           (err),
    .zf            (zf),
    .cf            (cf)
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Present one operation for exactly one edge once op_ready is high.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    int n = 0;
    while (op_ready !== 1'b1 && n < 100) begin
      step();
      n++;
    end
    checks++;
    if (op_ready !== 1'b1) begin
      errors++;
      $display("FAIL issue_ready: op_ready=%b required 1", op_ready);
    end
    opcode   = op;
    src_a    = a;
    src_b    = b;
    op_valid = 1'b1;
    step();
    op_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset    = 1'b0;
    opcode   = OP_ADD;
    src_a    = 32'h1;
    src_b    = 32'h2;
    op_valid = 1'b1;          // must not be accepted while in reset
    step();
    step();
    checks++;
    if ({write_data, read_or_write, done, err, zf, cf} !== 40'h0) begin
      errors++;
      $display("FAIL reset_outputs: wd=%h rw=%h done=%b err=%b zf=%b cf=%b required all 0",
               write_data, read_or_write, done, err, zf, cf);
    end
    op_valid = 1'b0;
    reset    = 1'b1;
    step();
    checks++;
    if (op_ready !== 1'b1 || done !== 1'b0 || read_or_write !== 4'h0 || write_data !== 32'h0) begin
      errors++;
      $display("FAIL reset_release: op_ready=%b done=%b rw=%h wd=%h required 1 0 0 0",
               op_ready, done, read_or_write, write_data);
    end
  endtask

  task automatic test_add_wrap();
    issue(OP_ADD, 32'hFFFF_FFFF, 32'h1);
    checks++;
    if (write_data !== 32'h0 || read_or_write !== WC || done !== 1'b1 || zf !== 1'b1 || cf !== 1'b1) begin
      errors++;
      $display("FAIL add_wrap: wd=%h rw=%h done=%b zf=%b cf=%b required 0 3 1 1 1",
               write_data, read_or_write, done, zf, cf);
    end
    checks++;
    if (op_ready !== 1'b0) begin
      errors++;
      $display("FAIL add_wb_ready: op_ready=%b required 0", op_ready);
    end
    step();
    checks++;
    if (read_or_write !== 4'h0 || done !== 1'b0 || op_ready !== 1'b1 || zf !== 1'b1 || cf !== 1'b1) begin
      errors++;
      $display("FAIL add_after_wb: rw=%h done=%b op_ready=%b zf=%b cf=%b required 0 0 1 1 1",
               read_or_write, done, op_ready, zf, cf);
    end
  endtask

  task automatic test_sub_mov();
    issue(OP_SUB, 32'h5, 32'h7);
    checks++;
    if (write_data !== 32'hFFFF_FFFE || cf !== 1'b1 || zf !== 1'b0 || read_or_write !== WC) begin
      errors++;
      $display("FAIL sub_borrow: wd=%h cf=%b zf=%b rw=%h required fffffffe 1 0 3",
               write_data, cf, zf, read_or_write);
    end
    issue(OP_MOV, 32'hDEAD_BEEF, 32'h0000_0999);
    checks++;
    if (write_data !== 32'h999 || cf !== 1'b0 || zf !== 1'b0 || done !== 1'b1) begin
      errors++;
      $display("FAIL mov: wd=%h cf=%b zf=%b done=%b required 999 0 0 1",
               write_data, cf, zf, done);
    end
  endtask

  // Back-to-back one-cycle ops from a vector table.
  task automatic test_back_to_back();
    logic [2:0]  ops [5] = '{OP_AND, OP_OR, OP_XOR, OP_ADD, OP_SUB};
    logic [31:0] va  [5] = '{32'hF0F0_FF00, 32'h1200_0034, 32'hA5A5_A5A5, 32'h7, 32'h9};
    logic [31:0] vb  [5] = '{32'h0FF0_F0F0, 32'h0034_1200, 32'hA5A5_A5A5, 32'h8, 32'h9};
    logic [31:0] vr  [5] = '{32'h00F0_F000, 32'h1234_1234, 32'h0,         32'hF, 32'h0};
    logic        vz  [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    for (int i = 0; i < 5; i++) begin
      issue(ops[i], va[i], vb[i]);
      checks++;
      if (write_data !== vr[i] || zf !== vz[i] || cf !== 1'b0 || read_or_write !== WC) begin
        errors++;
        $display("FAIL b2b_%0d: wd=%h zf=%b cf=%b rw=%h required %h %b 0 3",
                 i, write_data, zf, cf, read_or_write, vr[i], vz[i]);
      end
    end
  endtask

  task automatic test_shl();
    int lat;
    int low;
    int bad_rw;
    // Count 31: inputs toggle and op_valid stays high while busy; all ignored.
    issue(OP_SHL, 32'h1, 32'd31);
    lat = 1; low = 0; bad_rw = 0;
    while (done !== 1'b1 && lat < 100) begin
      if (op_ready === 1'b0) low++;
      if (read_or_write !== 4'h0) bad_rw++;
      opcode   = OP_MOV;
      src_a    = $urandom;
      src_b    = $urandom;
      op_valid = 1'b1;
      step();
      lat++;
    end
    op_valid = 1'b0;
    if (op_ready === 1'b0) low++;
    checks++;
    if (lat !== 32 || write_data !== 32'h8000_0000 || read_or_write !== WC) begin
      errors++;
      $display("FAIL shl31: latency=%0d wd=%h rw=%h required 32 80000000 3",
               lat, write_data, read_or_write);
    end
    checks++;
    if (low !== 32 || bad_rw !== 0) begin
      errors++;
      $display("FAIL shl31_busy: ready_low=%0d early_writes=%0d required 32 0", low, bad_rw);
    end
    step();
    checks++;
    if (op_ready !== 1'b1 || done !== 1'b0) begin
      errors++;
      $display("FAIL shl31_idle: op_ready=%b done=%b required 1 0", op_ready, done);
    end
    step();
    checks++;
    if (done !== 1'b0 || read_or_write !== 4'h0) begin
      errors++;
      $display("FAIL shl31_noqueue: done=%b rw=%h required 0 0", done, read_or_write);
    end
    // Count 3: latency 4.
    issue(OP_SHL, 32'h1, 32'd3);
    lat = 1;
    while (done !== 1'b1 && lat < 100) begin
      step();
      lat++;
    end
    checks++;
    if (lat !== 4 || write_data !== 32'h8) begin
      errors++;
      $display("FAIL shl3: latency=%0d wd=%h required 4 8", lat, write_data);
    end
    // Count 0 (upper bits of src_b ignored): latency 1, result src_a.
    issue(OP_SHL, 32'hABCD_1234, 32'hFFFF_FFE0);
    checks++;
    if (done !== 1'b1 || write_data !== 32'hABCD_1234 || cf !== 1'b0 || zf !== 1'b0) begin
      errors++;
      $display("FAIL shl0: done=%b wd=%h cf=%b zf=%b required 1 abcd1234 0 0",
               done, write_data, cf, zf);
    end
  endtask

  task automatic test_mul();
`ifdef ALU_MUL_EN
    int lat;
    issue(OP_MUL, 32'h1234, 32'h10);
    lat = 1;
    while (done !== 1'b1 && lat < 100) begin
      step();
      lat++;
    end
    checks++;
    if (lat !== 33 || write_data !== 32'h12340 || read_or_write !== WC || cf !== 1'b0) begin
      errors++;
      $display("FAIL mul: latency=%0d wd=%h rw=%h cf=%b required 33 12340 3 0",
               lat, write_data, read_or_write, cf);
    end
    issue(OP_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    lat = 1;
    while (done !== 1'b1 && lat < 100) begin
      step();
      lat++;
    end
    checks++;
    if (write_data !== 32'h1) begin
      errors++;
      $display("FAIL mul_wrap: wd=%h required 1", write_data);
    end
`else
    // Set known flags first, then MUL must leave them untouched.
    issue(OP_ADD, 32'hFFFF_FFFF, 32'h1);
    issue(OP_MUL, 32'h1234, 32'h10);
    checks++;
    if (err !== 1'b1 || done !== 1'b0 || read_or_write !== 4'h0 || write_data !== 32'h0 ||
        zf !== 1'b1 || cf !== 1'b1 || op_ready !== 1'b0) begin
      errors++;
      $display("FAIL mul_disabled: err=%b done=%b rw=%h wd=%h zf=%b cf=%b ready=%b required 1 0 0 0 1 1 0",
               err, done, read_or_write, write_data, zf, cf, op_ready);
    end
    step();
    checks++;
    if (err !== 1'b0 || op_ready !== 1'b1 || read_or_write !== 4'h0) begin
      errors++;
      $display("FAIL mul_disabled_end: err=%b ready=%b rw=%h required 0 1 0",
               err, op_ready, read_or_write);
    end
`endif
  endtask

  // Reset asserted at EXEC cycle 10 of a multi-cycle op.
  task automatic test_abort();
    int bad = 0;
    issue(OP_MOV, 32'h0, 32'h5A5A_0001);   // leave nonzero outputs behind
`ifdef ALU_MUL_EN
    issue(OP_MUL, 32'h1234, 32'h10);
`else
    issue(OP_SHL, 32'h1, 32'd31);
`endif
    for (int i = 1; i < 10; i++) begin
      if (read_or_write !== 4'h0 || done !== 1'b0) bad++;
      step();
    end
    reset = 1'b0;
    step();
    checks++;
    if ({write_data, read_or_write, done, err, zf, cf} !== 40'h0) begin
      errors++;
      $display("FAIL abort_outputs: wd=%h rw=%h done=%b err=%b zf=%b cf=%b required all 0",
               write_data, read_or_write, done, err, zf, cf);
    end
    reset = 1'b1;
    step();
    checks++;
    if (op_ready !== 1'b1) begin
      errors++;
      $display("FAIL abort_ready: op_ready=%b required 1", op_ready);
    end
    for (int i = 0; i < 40; i++) begin
      if (read_or_write !== 4'h0 || done !== 1'b0) bad++;
      step();
    end
    checks++;
    if (bad !== 0 || write_data !== 32'h0) begin
      errors++;
      $display("FAIL abort_nowrite: stray_writes=%0d wd=%h required 0 0", bad, write_data);
    end
  endtask

  initial begin
    test_reset();
    test_add_wrap();
    test_sub_mov();
    test_back_to_back();
    test_shl();
    test_mul();
    test_abort();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_writeback.md
ALU_WRITEBACK -- requirements
Module: alu_writeback

Interface
REQ-001 SHALL provide parameter WRITE_CODE, default 4'h3, code driven on read_or_write to request an eax write.
REQ-002 SHALL provide port clock, input, 1, sole clock; all state changes on its rising edge.
REQ-003 SHALL provide port reset, input, 1, synchronous active-low reset, sampled on rising clock.
REQ-004 SHALL provide port op_valid, input, 1, operation request valid.
REQ-005 SHALL provide port op_ready, output, 1, block can accept an operation.
REQ-006 SHALL provide port opcode, input, 3, 0 MOV, 1 ADD, 2 SUB, 3 AND, 4 OR, 5 XOR, 6 SHL, 7 MUL.
REQ-007 SHALL provide port src_a, input, 32, first operand, normally current eax.
REQ-008 SHALL provide port src_b, input, 32, second operand or immediate.
REQ-009 SHALL provide port write_data, output, 32, result for the eax register.
REQ-010 SHALL provide port read_or_write, output, 4, WRITE_CODE for one cycle per result, else 4'h0.
REQ-011 SHALL provide ports done, err, zf, cf, outputs, 1 each: result pulse, illegal-op pulse, zero flag, carry/borrow flag.

Function
REQ-012 SHALL implement states IDLE, EXEC, WB; op_ready = 1 only in IDLE.
REQ-013 Handshake: op accepted on rising clock with op_valid=1 and op_ready=1; opcode, src_a, src_b captured then; later input changes ignored until IDLE.
REQ-014 MOV/ADD/SUB/AND/OR/XOR: IDLE -> WB; result on write_data with read_or_write=WRITE_CODE and done=1 in the cycle after acceptance (latency 1).
REQ-015 ADD: 32-bit wrap, cf = carry out; SUB: src_a - src_b wrap, cf = 1 when src_a < src_b unsigned; MOV result = src_b; logic ops and MOV/SHL/MUL clear cf.
REQ-016 SHL: shift count = src_b[4:0]; IDLE -> EXEC, one bit left per cycle, count cycles, then WB; latency = count + 1; count 0 goes directly to WB (latency 1, result = src_a).
REQ-017 MUL (with ALU_MUL_EN): iterative shift-add, exactly 32 EXEC cycles, then WB; latency 33; result = low 32 bits of src_a*src_b unsigned.
REQ-018 WB lasts exactly one cycle, then IDLE; op_ready returns high the cycle after WB.
REQ-019 zf = (result == 0), updated only in WB; zf and cf hold between results.
REQ-020 Outside WB: read_or_write = 4'h0, done = 0; write_data holds last result.
REQ-021 op_valid while op_ready=0 SHALL be ignored, not queued.

Reset
REQ-022 reset=0 at a rising clock SHALL force IDLE, write_data=32'h0, read_or_write=4'h0, done=0, err=0, zf=0, cf=0; op_ready=1 from the first cycle after reset releases.
REQ-023 reset asserted during EXEC or WB SHALL abort the operation; no write code issued for it.
REQ-024 reset=0 coincident with op_valid=1 SHALL not accept the operation.

Configuration
REQ-025 Macro ALU_MUL_EN defined: MUL per REQ-017.
REQ-026 ALU_MUL_EN undefined: no multiplier logic; opcode 7 accepted, next cycle err=1 for one cycle, read_or_write=4'h0, done=0, flags and write_data unchanged, then IDLE.

Verification
REQ-027 Reset low 2 cycles, release -> all outputs zero, op_ready=1.
REQ-028 ADD src_a=32'hFFFF_FFFF, src_b=1 -> next cycle write_data=0, read_or_write=4'h3, done=1, zf=1, cf=1.
REQ-029 SUB src_a=5, src_b=7 -> write_data=32'hFFFF_FFFE, cf=1, zf=0; then MOV src_b=32'h0000_0999 -> write_data=32'h999, cf=0.
REQ-030 SHL src_a=1, src_b=31 -> op_ready low 32 cycles, write at cycle 32: 32'h8000_0000; SHL count 0 -> latency 1, result = src_a.
REQ-031 MUL 32'h1234 x 32'h10 with ALU_MUL_EN -> write at cycle 33: 32'h12340; without macro -> err pulse, no write code.
REQ-032 Reset low at EXEC cycle 10 of MUL -> no write code ever issued, outputs zero, op_ready=1 next cycle after release.
